decoder_4to16: RTL and testbench
================================

DECODER_4TO16 -- requirements
Module: decoder_4to16

Interface
REQ-001 The block SHALL have parameter ACTIVE_LOW, default 0, meaning 0 = selected output line driven 1, 1 = selected line driven 0 and all other lines driven 1.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port en, input, 1 bit: decode enable.
REQ-005 The block SHALL have port a, input, 4 bits: binary select code, unsigned 0..15.
REQ-006 The block SHALL have port d, output, 16 bits: registered one-hot decode of a; bit i corresponds to code i.
REQ-007 The block SHALL have port valid, output, 1 bit: registered flag; 1 when d holds a decode of an enabled sample.

Function
REQ-008 The block SHALL be built from two 3-to-8 decoder stages: stage LO covers d[7:0], stage HI covers d[15:8]; a[2:0] feeds both; a[3]=0 enables LO only, a[3]=1 enables HI only.
REQ-009 Each 3-to-8 stage SHALL, when enabled, assert exactly bit a[2:0] of its 8-bit output and deassert the rest; when disabled, it SHALL deassert all 8 bits.
REQ-010 With ACTIVE_LOW=0, the next-state value of d SHALL be (1 << a) when en=1, and 16'h0000 when en=0.
REQ-011 With ACTIVE_LOW=1, the next-state value of d SHALL be the bitwise inverse of the ACTIVE_LOW=0 value: ~(1 << a) when en=1, and 16'hFFFF when en=0.
REQ-012 On each rising clk edge with rst=0, d SHALL load the next-state value from REQ-010/REQ-011 and valid SHALL load en; latency from a/en to d/valid is exactly 1 cycle.
REQ-013 While en=1 and rst=0, exactly one bit of d SHALL be in the asserted state after every clock edge, for all 16 codes, including the boundary codes 0 and 15.
REQ-014 The block SHALL have no combinational path from any input to d or valid.
REQ-015 A change of a on consecutive cycles SHALL be reflected cycle-for-cycle, with no hold-over or skipped codes.

Reset
REQ-016 When rst=1 at a rising clk edge, d SHALL become all-deasserted (16'h0000 for ACTIVE_LOW=0, 16'hFFFF for ACTIVE_LOW=1) and valid SHALL become 0.
REQ-017 rst SHALL take priority over en and a when both are active at the same edge, including a reset asserted mid-sequence.
REQ-018 On the first edge after rst deasserts, the block SHALL resume normal decoding per REQ-012; no extra idle cycle SHALL be inserted.
REQ-019 Before the first reset edge, output values SHALL be unspecified; the verification bench SHALL apply rst for at least 1 cycle.

Verification
REQ-020 Sweep test: rst 1 cycle, then en=1 with a=0..15 on consecutive cycles (ACTIVE_LOW=0) -> one cycle later d=0x0001, 0x0002, 0x0004, ..., 0x8000 and valid=1 on every cycle.
REQ-021 Stage boundary test: en=1 with a=7 then a=8 -> d=0x0080 then 0x0100; only the LO stage is active for a=7 and only the HI stage for a=8.
REQ-022 Enable test: en=0 with a=5 -> next cycle d=0x0000 and valid=0; set en=1 -> next cycle d=0x0020 and valid=1.
REQ-023 Reset priority test: decode a=12 (d=0x1000), then rst=1 with en=1 and a=3 -> d=0x0000 and valid=0; rst=0 -> next cycle d=0x0008.
REQ-024 Active-low test: with ACTIVE_LOW=1, en=1 and a=0 -> d=0xFFFE; a=15 -> d=0x7FFF; en=0 -> d=0xFFFF; rst=1 -> d=0xFFFF and valid=0.
REQ-025 Checker: on every cycle with valid=1, the bench SHALL confirm that d has exactly one asserted bit and that this bit's index equals the value of a from the previous cycle.

Source files
------------

// File: rtl/decoder_4to16.sv
// Registered 4-to-16 one-hot decoder built from two 3-to-8 stages.
// Ports: clk, rst (sync, active-high), en, a[3:0] in; d[15:0], valid out.
//
// decoder_3to8 : en_i enables the stage, a_i selects the line, y_o is
//                the active-high one-hot result (all zero when disabled).
// decoder_4to16: ACTIVE_LOW=0 drives the selected line of d high;
//                ACTIVE_LOW=1 drives it low and every other line high.
//                d and valid are registered, one cycle after a/en.

module decoder_3to8 (
    input  logic       en_i,
    input  logic [2:0] a_i,
    output logic [7:0] y_o
);

    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o[a_i] = 1'b1;
        end
    end

endmodule

module decoder_4to16 #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  a,
    output logic [15:0] d,
    output logic        valid
);

    // Polarity mask: XOR turns the active-high decode into active-low,
    // and doubles as the all-deasserted value for reset and disable.
    localparam logic [15:0] POL = {16{ACTIVE_LOW}};

    logic [7:0]  lo_y;
    logic [7:0]  hi_y;
    logic        lo_en;
    logic        hi_en;
    logic [15:0] d_d;
    logic [15:0] d_q;
    logic        valid_d;
    logic        valid_q;

    // a[3] steers the global enable to exactly one stage.
    assign lo_en = en & ~a[3];
    assign hi_en = en &  a[3];

    decoder_3to8 u_lo (
        .en_i (lo_en),
        .a_i  (a[2:0]),
        .y_o  (lo_y)
    );

    decoder_3to8 u_hi (
        .en_i (hi_en),
        .a_i  (a[2:0]),
        .y_o  (hi_y)
    );

    assign d_d     = {hi_y, lo_y} ^ POL;
    assign valid_d = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q     <= POL;
            valid_q <= 1'b0;
        end else begin
            d_q     <= d_d;
            valid_q <= valid_d;
        end
    end

    assign d     = d_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_decoder_4to16.sv
// Scoreboard bench for decoder_4to16, both polarities side by side.
// Driver pushes hand-computed expectations; monitor pops and compares.

module tb_decoder_4to16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [3:0]  a   = 4'd0;
    logic [15:0] d_h;
    logic [15:0] d_l;
    logic        v_h;
    logic        v_l;

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  a;
        logic [15:0] dh;
        logic [15:0] dl;
        logic        v;
    } vec_t;

    typedef struct {
        logic [15:0] dh;
        logic [15:0] dl;
        logic        v;
        int          idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   drv_done = 1'b0;

    always #5 clk = ~clk;

    decoder_4to16 #(.ACTIVE_LOW(1'b0)) u_ah (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a     (a),
        .d     (d_h),
        .valid (v_h)
    );

    decoder_4to16 #(.ACTIVE_LOW(1'b1)) u_al (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a     (a),
        .d     (d_l),
        .valid (v_l)
    );

    task automatic add(input logic r, input logic e, input logic [3:0] s,
                       input logic [15:0] dh, input logic [15:0] dl,
                       input logic v);
        vec_t t;
        t.rst = r; t.en = e; t.a = s; t.dh = dh; t.dl = dl; t.v = v;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic int popcnt(input logic [15:0] x);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(x[i]);
        return n;
    endfunction

    // Driver: apply vectors on the falling edge, log expectations.
    initial begin
        exp_t e;
        add(1, 0, 4'd0,  16'h0000, 16'hFFFF, 0);
        add(0, 1, 4'd0,  16'h0001, 16'hFFFE, 1);
        add(0, 1, 4'd1,  16'h0002, 16'hFFFD, 1);
        add(0, 1, 4'd2,  16'h0004, 16'hFFFB, 1);
        add(0, 1, 4'd3,  16'h0008, 16'hFFF7, 1);
        add(0, 1, 4'd4,  16'h0010, 16'hFFEF, 1);
        add(0, 1, 4'd5,  16'h0020, 16'hFFDF, 1);
        add(0, 1, 4'd6,  16'h0040, 16'hFFBF, 1);
        add(0, 1, 4'd7,  16'h0080, 16'hFF7F, 1);
        add(0, 1, 4'd8,  16'h0100, 16'hFEFF, 1);
        add(0, 1, 4'd9,  16'h0200, 16'hFDFF, 1);
        add(0, 1, 4'd10, 16'h0400, 16'hFBFF, 1);
        add(0, 1, 4'd11, 16'h0800, 16'hF7FF, 1);
        add(0, 1, 4'd12, 16'h1000, 16'hEFFF, 1);
        add(0, 1, 4'd13, 16'h2000, 16'hDFFF, 1);
        add(0, 1, 4'd14, 16'h4000, 16'hBFFF, 1);
        add(0, 1, 4'd15, 16'h8000, 16'h7FFF, 1);
        add(0, 1, 4'd7,  16'h0080, 16'hFF7F, 1);
        add(0, 1, 4'd8,  16'h0100, 16'hFEFF, 1);
        add(0, 0, 4'd5,  16'h0000, 16'hFFFF, 0);
        add(0, 1, 4'd5,  16'h0020, 16'hFFDF, 1);
        add(0, 1, 4'd12, 16'h1000, 16'hEFFF, 1);
        add(1, 1, 4'd3,  16'h0000, 16'hFFFF, 0);
        add(0, 1, 4'd3,  16'h0008, 16'hFFF7, 1);
        add(0, 1, 4'd0,  16'h0001, 16'hFFFE, 1);
        add(0, 1, 4'd15, 16'h8000, 16'h7FFF, 1);
        add(0, 0, 4'd15, 16'h0000, 16'hFFFF, 0);
        add(0, 1, 4'd9,  16'h0200, 16'hFDFF, 1);
        add(1, 1, 4'd9,  16'h0000, 16'hFFFF, 0);
        add(1, 0, 4'd2,  16'h0000, 16'hFFFF, 0);
        add(0, 1, 4'd2,  16'h0004, 16'hFFFB, 1);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            en  = vecs[i].en;
            a   = vecs[i].a;
            e.dh = vecs[i].dh;
            e.dl = vecs[i].dl;
            e.v  = vecs[i].v;
            e.idx = i;
            sb.push_back(e);
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        drv_done = 1'b1;
    end

    // Monitor: one output per clock; pop and compare after each edge.
    always @(posedge clk) begin
        exp_t        e;
        logic [3:0]  a_s;
        logic        en_s;
        logic        rst_s;
        logic [15:0] inv;
        a_s   = a;
        en_s  = en;
        rst_s = rst;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("v%0d_d_ah", e.idx), d_h, e.dh);
            chk($sformatf("v%0d_d_al", e.idx), d_l, e.dl);
            chk($sformatf("v%0d_valid_ah", e.idx), {15'd0, v_h}, {15'd0, e.v});
            chk($sformatf("v%0d_valid_al", e.idx), {15'd0, v_l}, {15'd0, e.v});
            // Structural check: one hot line at the previous-cycle code.
            if (v_h === 1'b1 && !rst_s && en_s) begin
                chk($sformatf("v%0d_onehot_ah", e.idx),
                    16'(popcnt(d_h)), 16'd1);
                chk($sformatf("v%0d_index_ah", e.idx),
                    {15'd0, d_h[a_s]}, 16'd1);
            end
            if (v_l === 1'b1 && !rst_s && en_s) begin
                inv = ~d_l;
                chk($sformatf("v%0d_onehot_al", e.idx),
                    16'(popcnt(inv)), 16'd1);
                chk($sformatf("v%0d_index_al", e.idx),
                    {15'd0, inv[a_s]}, 16'd1);
            end
        end
    end

    // Finish once the scoreboard drains, with a hard cycle bound.
    initial begin
        int cyc = 0;
        while (!(drv_done && sb.size() == 0) && cyc < 1000) begin
            @(posedge clk);
            cyc++;
        end
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0 || !drv_done) begin
            failures++;
            $display("FAIL drain: pending %0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
